// File: rtl/maze_defs.sv
// Shared definitions for the maze game controller: FSM state encoding,
// default level/frame counts and the visible screen limits.
package maze_defs;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_PLAY  = 3'd2,
    S_LVLUP = 3'd3,
    S_SCARE = 3'd4,
    S_WIN   = 3'd5
  } state_t;

  localparam int NUM_LEVELS_DEF   = 3;
  localparam int LVLUP_FRAMES_DEF = 60;
  localparam int SCARE_FRAMES_DEF = 180;

  localparam logic [9:0] SCR_W = 10'd640;
  localparam logic [9:0] SCR_H = 10'd480;

endpackage

// File: rtl/cursor_probe.sv
// Cursor probe: latches what the graphics say about the pixel under the
// player cursor during the visible frame, and clears on the cycle after
// refr_tick so each frame starts from a clean probe.
// Ports:
//   clk, reset            clock, async active-low reset
//   refr_tick             per-frame pulse (FSM samples the probe on it)
//   video_on, pix_x/y     scan position and visible-area flag
//   cur_x/y               player cursor position
//   graph_on, finalbox_on path / goal pixel flags of the selected level
//   seen, on_path, on_goal probe results for the current frame
module cursor_probe
  import maze_defs::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       refr_tick,
  input  logic       video_on,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic [9:0] cur_x,
  input  logic [9:0] cur_y,
  input  logic       graph_on,
  input  logic       finalbox_on,
  output logic       seen,
  output logic       on_path,
  output logic       on_goal
);

  logic tick_d;
  logic on_screen;
  logic hit;

  // An off-screen cursor can never be seen, so it reads as a wall in PLAY.
  assign on_screen = (cur_x < SCR_W) && (cur_y < SCR_H);
  assign hit       = video_on && on_screen && (pix_x == cur_x) && (pix_y == cur_y);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_d  <= 1'b0;
      seen    <= 1'b0;
      on_path <= 1'b0;
      on_goal <= 1'b0;
    end else begin
      tick_d <= refr_tick;
      // Clear one cycle after the tick: the FSM has already consumed the
      // ending frame's values on the tick edge itself.
      if (tick_d) begin
        seen    <= 1'b0;
        on_path <= 1'b0;
        on_goal <= 1'b0;
      end else if (hit) begin
        seen    <= 1'b1;
        on_path <= graph_on;
        on_goal <= finalbox_on;
      end
    end
  end

endmodule

// File: rtl/maze_game_ctrl.sv
// Maze game controller: frame-rate FSM that arms on start, plays while the
// cursor stays on the path, advances levels on the goal box, scares on a
// wall hit and shows a win screen after the last level.
// Ports:
//   clk, reset            clock, async active-low reset
//   start                 debounced button; rising edge starts/restarts
//   refr_tick             one-cycle pulse per frame; FSM steps only here
//   video_on, pix_x/y     scan position
//   cur_x/y               player cursor
//   graph_on, finalbox_on selected level's path / goal pixel flags
//   level                 level index for the graphics mux
//   play_on/scare_on/win_on  screen mode flags
//   scare_pulse           one-clk pulse on PLAY->SCARE (audio trigger)
module maze_game_ctrl
  import maze_defs::*;
#(
  parameter int NUM_LEVELS   = NUM_LEVELS_DEF,
  parameter int LVLUP_FRAMES = LVLUP_FRAMES_DEF,
  parameter int SCARE_FRAMES = SCARE_FRAMES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       refr_tick,
  input  logic       video_on,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic [9:0] cur_x,
  input  logic [9:0] cur_y,
  input  logic       graph_on,
  input  logic       finalbox_on,
  output logic [1:0] level,
  output logic       play_on,
  output logic       scare_on,
  output logic       win_on,
  output logic       scare_pulse
);

  localparam logic [1:0] LVL_MAX  = 2'(NUM_LEVELS - 1);
  localparam logic [7:0] LV_LAST  = (LVLUP_FRAMES > 256) ? 8'd255 : 8'(LVLUP_FRAMES - 1);
  localparam logic [7:0] SC_LAST  = (SCARE_FRAMES > 256) ? 8'd255 : 8'(SCARE_FRAMES - 1);

  state_t     state, state_nx;
  logic [1:0] level_nx;
  logic [7:0] cnt, cnt_nx, cnt_inc;
  logic       start_q, start_pend, start_rise, start_evt;
  logic       scare_go;
  logic       seen, on_path, on_goal;

  cursor_probe u_probe (
    .clk         (clk),
    .reset       (reset),
    .refr_tick   (refr_tick),
    .video_on    (video_on),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .cur_x       (cur_x),
    .cur_y       (cur_y),
    .graph_on    (graph_on),
    .finalbox_on (finalbox_on),
    .seen        (seen),
    .on_path     (on_path),
    .on_goal     (on_goal)
  );

  // A start edge can arrive anywhere in the frame but the FSM only steps on
  // refr_tick, so the edge is held until the next tick consumes it.
  assign start_rise = start & ~start_q;
  assign start_evt  = start_pend | start_rise;
  assign cnt_inc    = (cnt == 8'hFF) ? cnt : cnt + 8'd1;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      level       <= 2'd0;
      cnt         <= 8'd0;
      start_q     <= 1'b0;
      start_pend  <= 1'b0;
      scare_pulse <= 1'b0;
    end else begin
      start_q     <= start;
      start_pend  <= refr_tick ? 1'b0 : start_evt;
      scare_pulse <= scare_go;
      if (refr_tick) begin
        state <= state_nx;
        level <= level_nx;
        cnt   <= cnt_nx;
      end
    end
  end

  // Next-state logic (only committed on refr_tick)
  always_comb begin
    state_nx = state;
    level_nx = level;
    cnt_nx   = cnt;
    case (state)
      S_IDLE: begin
        if (start_evt) begin
          state_nx = S_ARM;
          level_nx = 2'd0;
          cnt_nx   = 8'd0;
        end
      end
      S_ARM: begin
        if (start_evt) begin
          level_nx = 2'd0;
          cnt_nx   = 8'd0;
        end else if (seen && on_path) begin
          state_nx = S_PLAY;
        end
      end
      S_PLAY: begin
        if (start_evt) begin
          state_nx = S_ARM;
          level_nx = 2'd0;
          cnt_nx   = 8'd0;
        end else if (seen && on_goal) begin
          // Goal wins over wall when both flags are set on the cursor pixel.
          cnt_nx   = 8'd0;
          state_nx = (level < LVL_MAX) ? S_LVLUP : S_WIN;
        end else if (!seen || !on_path) begin
          state_nx = S_SCARE;
          cnt_nx   = 8'd0;
        end
      end
      S_LVLUP: begin
        if (start_evt) begin
          state_nx = S_ARM;
          level_nx = 2'd0;
          cnt_nx   = 8'd0;
        end else if (cnt == LV_LAST) begin
          state_nx = S_ARM;
          level_nx = (level < LVL_MAX) ? level + 2'd1 : level;
          cnt_nx   = 8'd0;
        end else begin
          cnt_nx = cnt_inc;
        end
      end
      S_SCARE: begin
        // Start is deliberately ignored while the scare screen runs.
        if (cnt == SC_LAST) begin
          state_nx = S_IDLE;
          level_nx = 2'd0;
          cnt_nx   = 8'd0;
        end else begin
          cnt_nx = cnt_inc;
        end
      end
      S_WIN: begin
        if (start_evt) begin
          state_nx = S_ARM;
          level_nx = 2'd0;
          cnt_nx   = 8'd0;
        end
      end
      default: begin
        state_nx = S_IDLE;
        level_nx = 2'd0;
        cnt_nx   = 8'd0;
      end
    endcase
  end

  assign scare_go = refr_tick && (state == S_PLAY) && (state_nx == S_SCARE);

  // Output decode
  always_comb begin
    play_on  = 1'b0;
    scare_on = 1'b0;
    win_on   = 1'b0;
    case (state)
      S_ARM, S_PLAY: play_on  = 1'b1;
      S_SCARE:       scare_on = 1'b1;
      S_WIN:         win_on   = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_maze_game_ctrl.sv
module tb_maze_game_ctrl;

  localparam int NL = 3;
  localparam int LF = 60;
  localparam int SF = 180;

  // reference-model modes
  localparam int M_IDLE = 0, M_ARM = 1, M_PLAY = 2, M_LVLUP = 3, M_SCARE = 4, M_WIN = 5;

  typedef struct packed {
    logic [1:0] lvl;
    logic       play;
    logic       scare;
    logic       win;
    logic       pulse;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       refr_tick = 1'b0;
  logic       video_on = 1'b0;
  logic [9:0] pix_x = '0, pix_y = '0, cur_x = '0, cur_y = '0;
  logic       graph_on = 1'b0, finalbox_on = 1'b0;
  logic [1:0] level;
  logic       play_on, scare_on, win_on, scare_pulse;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  int m_st = M_IDLE;
  int m_lvl = 0;
  int m_el = 0;

  maze_game_ctrl #(.NUM_LEVELS(NL), .LVLUP_FRAMES(LF), .SCARE_FRAMES(SF)) dut (
    .clk(clk), .reset(reset), .start(start), .refr_tick(refr_tick),
    .video_on(video_on), .pix_x(pix_x), .pix_y(pix_y), .cur_x(cur_x), .cur_y(cur_y),
    .graph_on(graph_on), .finalbox_on(finalbox_on), .level(level),
    .play_on(play_on), .scare_on(scare_on), .win_on(win_on), .scare_pulse(scare_pulse)
  );

  always #5 clk = ~clk;

  // Monitor: every frame tick the DUT presents a new screen mode; compare it
  // with the oldest prediction. Between ticks scare_pulse must stay low.
  bit mon_t;
  always begin
    @(posedge clk);
    mon_t = refr_tick & reset;
    @(negedge clk);
    if (mon_t) begin
      exp_t e;
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL sb_underflow: DUT ticked with no expected entry");
      end else begin
        e = sb.pop_front();
        if ({level, play_on, scare_on, win_on, scare_pulse} !== e) begin
          n_err++;
          $display("FAIL frame_out: got lvl=%0d play=%b scare=%b win=%b pulse=%b, want lvl=%0d play=%b scare=%b win=%b pulse=%b",
                   level, play_on, scare_on, win_on, scare_pulse, e.lvl, e.play, e.scare, e.win, e.pulse);
        end
      end
    end else if (reset) begin
      n_vec++;
      if (scare_pulse !== 1'b0) begin
        n_err++;
        $display("FAIL pulse_extra: scare_pulse=%b between ticks, want 0", scare_pulse);
      end
    end
  end

  task automatic check_zero(input string nm);
    n_vec++;
    if ({level, play_on, scare_on, win_on, scare_pulse} !== 6'd0) begin
      n_err++;
      $display("FAIL %s: got lvl=%0d play=%b scare=%b win=%b pulse=%b, want all 0",
               nm, level, play_on, scare_on, win_on, scare_pulse);
    end
  endtask

  // Game rules applied once per frame to what the cursor saw.
  task automatic model_step(input bit seen, input bit path_px, input bit goal_px, input bit se);
    bit path, goal, pulse;
    exp_t e;
    path  = seen && path_px;
    goal  = seen && goal_px;
    pulse = 1'b0;
    case (m_st)
      M_IDLE:  if (se) begin m_st = M_ARM; m_lvl = 0; end
      M_ARM:   if (se) m_lvl = 0; else if (path) m_st = M_PLAY;
      M_PLAY: begin
        if (se) begin m_st = M_ARM; m_lvl = 0; end
        else if (goal) begin
          if (m_lvl < NL - 1) begin m_st = M_LVLUP; m_el = 0; end
          else m_st = M_WIN;
        end else if (!path) begin m_st = M_SCARE; m_el = 0; pulse = 1'b1; end
      end
      M_LVLUP: begin
        if (se) begin m_st = M_ARM; m_lvl = 0; end
        else begin
          m_el++;
          if (m_el == LF) begin m_st = M_ARM; m_lvl++; end
        end
      end
      M_SCARE: begin
        m_el++;
        if (m_el == SF) begin m_st = M_IDLE; m_lvl = 0; end
      end
      default: if (se) begin m_st = M_ARM; m_lvl = 0; end
    endcase
    e.lvl   = 2'(m_lvl);
    e.play  = (m_st == M_ARM) || (m_st == M_PLAY);
    e.scare = (m_st == M_SCARE);
    e.win   = (m_st == M_WIN);
    e.pulse = pulse;
    sb.push_back(e);
  endtask

  // One compressed frame: noise pixel, the probe pixel (matching the cursor
  // when hit=1), a blanked pixel at the cursor, then refr_tick.
  task automatic frame(input int cx, input int cy, input bit hit, input bit g,
                       input bit f, input bit se, input bit rst_mid);
    bit on;
    cur_x = 10'(cx);
    cur_y = 10'(cy);
    @(negedge clk);
    video_on = 1'b1; pix_x = 10'(cx + 1); pix_y = 10'(cy);
    graph_on = 1'($urandom_range(0, 1)); finalbox_on = 1'($urandom_range(0, 1));
    if (se) start = 1'b1;
    @(negedge clk);
    pix_x = hit ? 10'(cx) : 10'(cx + 2); pix_y = 10'(cy);
    graph_on = g; finalbox_on = f;
    @(negedge clk);
    if (rst_mid) begin
      reset = 1'b0;
      #1 check_zero("reset_mid_frame");
      m_st = M_IDLE; m_lvl = 0; m_el = 0;
      @(negedge clk);
      reset = 1'b1;
    end
    video_on = 1'b0; pix_x = 10'(cx); pix_y = 10'(cy);
    graph_on = 1'($urandom_range(0, 1)); finalbox_on = 1'($urandom_range(0, 1));
    start = 1'b0;
    @(negedge clk);
    refr_tick = 1'b1; pix_x = 10'd0; pix_y = 10'd481;
    on = (cx < 640) && (cy < 480);
    model_step(hit && on && !rst_mid, g, f, se);
    @(negedge clk);
    refr_tick = 1'b0; pix_y = 10'd482;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    reset = 1'b1;
    @(negedge clk);
    check_zero("idle_after_reset");

    // start, then onto the path
    frame(170, 300, 1, 1, 0, 1, 0);
    frame(170, 300, 1, 1, 0, 0, 0);
    // goal on level 0, wait out LVLUP, arm and play level 1
    frame(170, 300, 1, 1, 1, 0, 0);
    repeat (LF) frame(170, 300, 1, 1, 0, 0, 0);
    frame(170, 300, 1, 1, 0, 0, 0);
    // level 1 goal with path flag also set
    frame(170, 410, 1, 1, 1, 0, 0);
    repeat (LF) frame(170, 300, 1, 1, 0, 0, 0);
    frame(170, 300, 1, 1, 0, 0, 0);
    // last level goal -> win, then restart
    frame(170, 410, 1, 1, 1, 0, 0);
    frame(170, 300, 1, 1, 0, 0, 0);
    frame(170, 300, 1, 1, 0, 1, 0);
    frame(170, 300, 1, 1, 0, 0, 0);
    // wall hit, with a start edge mid-scare
    frame(100, 100, 1, 0, 0, 0, 0);
    for (int i = 0; i < SF; i++) frame(100, 100, 1, 0, 0, i == 90, 0);
    // off-screen cursor in PLAY
    frame(170, 300, 1, 1, 0, 1, 0);
    frame(170, 300, 1, 1, 0, 0, 0);
    frame(700, 300, 1, 1, 0, 0, 0);
    repeat (SF) frame(700, 300, 1, 1, 0, 0, 0);
    // reset mid-PLAY
    frame(170, 300, 1, 1, 0, 1, 0);
    frame(170, 300, 1, 1, 0, 0, 0);
    frame(170, 300, 1, 1, 0, 0, 1);
    frame(170, 300, 1, 1, 0, 0, 0);

    // randomized play
    for (int k = 0; k < 1500; k++) begin
      int  r, cx, cy;
      bit  se, hit, g, f, rm;
      r  = $urandom_range(0, 99);
      se = (r < 4) || (((m_st == M_IDLE) || (m_st == M_WIN)) && (r < 30));
      if ($urandom_range(0, 19) == 0) begin
        if ($urandom_range(0, 1) == 1) begin
          cx = $urandom_range(640, 1023); cy = $urandom_range(0, 479);
        end else begin
          cx = $urandom_range(0, 639); cy = $urandom_range(480, 1023);
        end
      end else begin
        cx = $urandom_range(0, 639); cy = $urandom_range(0, 479);
      end
      hit = ($urandom_range(0, 19) != 0);
      g   = ($urandom_range(0, 9) != 0);
      f   = ($urandom_range(0, 9) == 0);
      rm  = ($urandom_range(0, 299) == 0) && !se;
      frame(cx, cy, hit, g, f, se, rm);
    end

    repeat (3) @(negedge clk);
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_leftover: %0d expected frames never seen, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
